// File: rtl/processor_if.sv
// processor_if: visibility bundle exported by the processor core plus the
// program-load port used to fill the instruction ROM.
`default_nettype none

interface processor_if;
  logic [15:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [1:0]  PS;
  logic [15:0] databus;
  logic [15:0] addressbus;
  logic        WR;
  logic [46:0] ControlWord;
  logic [15:0] K;
  logic [2:0]  AA, BA, DA;
  logic [3:0]  status;
  logic [4:0]  FS;
  logic        C0, PCSEL, EN_ALU, EN_ADDRESS_ALU, IR_EN, EN_ADDRESS_PC;
  logic        EN_PC, MW, MR, BSEL, ROM_EN, EN_B;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;

  modport master (
    output R0, R1, R2, R3, R4, R5, R6, R7, PS, databus, addressbus, WR,
           ControlWord, K, AA, BA, DA, status, FS, C0, PCSEL, EN_ALU,
           EN_ADDRESS_ALU, IR_EN, EN_ADDRESS_PC, EN_PC, MW, MR, BSEL,
           ROM_EN, EN_B,
    input  prog_we, prog_addr, prog_data
  );

  modport slave (
    input  R0, R1, R2, R3, R4, R5, R6, R7, PS, databus, addressbus, WR,
           ControlWord, K, AA, BA, DA, status, FS, C0, PCSEL, EN_ALU,
           EN_ADDRESS_ALU, IR_EN, EN_ADDRESS_PC, EN_PC, MW, MR, BSEL,
           ROM_EN, EN_B,
    output prog_we, prog_addr, prog_data
  );
endinterface

`default_nettype wire

// File: rtl/processor.sv
// processor: 16-bit multicycle core (FETCH/EXEC microcode, 8x16 regfile, ALU,
// 256-word ROM loaded through the program port, 256-word RAM).
`default_nettype none

module processor (
  input  logic        clock,
  input  logic        reset,
  processor_if.master bus
);
  typedef enum logic [1:0] {FETCH = 2'b00, EXEC = 2'b01, HALT = 2'b10} state_t;

  state_t      state_q, state_d;
  logic [15:0] regs_q [8];
  logic [15:0] pc_q, pc_d, ir_q;
  logic [3:0]  status_q;
  logic [15:0] rom_q [256];
  logic [15:0] ram_q [256];

  logic [46:0] cw;
  logic        alu_op;
  logic [2:0]  da, aa, ba;
  logic [15:0] k;
  logic [4:0]  fs;
  logic [1:0]  ps;
  logic        wr, c0, pcsel, en_alu, en_addr_alu, ir_en, en_addr_pc;
  logic        en_pc, mw, mr, bsel, rom_en, en_b;

  logic [15:0] a_op, b_op, b_eff, alu, databus, addr;
  logic [16:0] sum;
  logic        carry, ovf;

  // Microword generation
  always_comb begin
    cw     = '0;
    alu_op = 1'b0;
    case (state_q)
      FETCH: begin
        cw[46:45] = EXEC;
        cw[14:13] = 2'b01;
        cw[7]     = 1'b1;
        cw[6]     = 1'b1;
        cw[1]     = 1'b1;
      end
      EXEC: begin
        cw[46:45] = FETCH;
        cw[44:42] = ir_q[11:9];
        cw[41:39] = ir_q[8:6];
        cw[38:36] = ir_q[5:3];
        cw[35:20] = {{10{ir_q[5]}}, ir_q[5:0]};
        case (ir_q[15:12])
          4'h1: begin cw[19:15] = 5'd0; alu_op = 1'b1; end
          4'h2: begin cw[19:15] = 5'd1; cw[11] = 1'b1; alu_op = 1'b1; end
          4'h3: begin cw[19:15] = 5'd2; alu_op = 1'b1; end
          4'h4: begin cw[19:15] = 5'd3; alu_op = 1'b1; end
          4'h5: begin cw[19:15] = 5'd4; alu_op = 1'b1; end
          4'h6: begin cw[19:15] = 5'd5; alu_op = 1'b1; end
          4'h7: begin cw[19:15] = 5'd6; alu_op = 1'b1; end
          4'h8: begin cw[19:15] = 5'd7; alu_op = 1'b1; end
          4'h9: begin cw[19:15] = 5'd0; cw[2] = 1'b1; alu_op = 1'b1; end
          4'hA: begin cw[19:15] = 5'd8; cw[2] = 1'b1; alu_op = 1'b1; end
          4'hB: begin cw[19:15] = 5'd9; cw[8] = 1'b1; cw[3] = 1'b1; cw[12] = 1'b1; end
          4'hC: begin cw[19:15] = 5'd9; cw[8] = 1'b1; cw[0] = 1'b1; cw[4] = 1'b1; end
          4'hD: begin cw[14:13] = 2'b10; cw[10] = 1'b1; end
          4'hE: cw[14:13] = 2'b11;
          4'hF: cw[46:45] = HALT;
          default: ;
        endcase
        if (alu_op) begin
          cw[12] = 1'b1;
          cw[9]  = 1'b1;
        end
      end
      default: cw[46:45] = HALT;
    endcase
  end

  assign state_d     = state_t'(cw[46:45]);
  assign da          = cw[44:42];
  assign aa          = cw[41:39];
  assign ba          = cw[38:36];
  assign k           = cw[35:20];
  assign fs          = cw[19:15];
  assign ps          = cw[14:13];
  assign wr          = cw[12];
  assign c0          = cw[11];
  assign pcsel       = cw[10];
  assign en_alu      = cw[9];
  assign en_addr_alu = cw[8];
  assign ir_en       = cw[7];
  assign en_addr_pc  = cw[6];
  assign en_pc       = cw[5];
  assign mw          = cw[4];
  assign mr          = cw[3];
  assign bsel        = cw[2];
  assign rom_en      = cw[1];
  assign en_b        = cw[0];

  // ALU; subtract reuses the adder with an inverted B operand
  always_comb begin
    a_op  = regs_q[aa];
    b_op  = bsel ? k : regs_q[ba];
    b_eff = (fs == 5'd1) ? ~b_op : b_op;
    sum   = {1'b0, a_op} + {1'b0, b_eff} + {16'd0, c0};
    carry = 1'b0;
    ovf   = 1'b0;
    case (fs)
      5'd0, 5'd1: begin
        alu   = sum[15:0];
        carry = sum[16];
        ovf   = (a_op[15] == b_eff[15]) && (sum[15] != a_op[15]);
      end
      5'd2:    alu = a_op & b_op;
      5'd3:    alu = a_op | b_op;
      5'd4:    alu = a_op ^ b_op;
      5'd5:    alu = ~a_op;
      5'd6:    alu = {a_op[14:0], 1'b0};
      5'd7:    alu = {1'b0, a_op[15:1]};
      5'd8:    alu = b_op;
      default: alu = a_op;
    endcase
  end

  always_comb begin
    if (en_addr_pc)       addr = pc_q;
    else if (en_addr_alu) addr = alu;
    else                  addr = '0;

    if (rom_en)      databus = rom_q[addr[7:0]];
    else if (mr)     databus = ram_q[addr[7:0]];
    else if (en_alu) databus = alu;
    else if (en_pc)  databus = pc_q;
    else if (en_b)   databus = b_op;
    else             databus = '0;
  end

  always_comb begin
    case (ps)
      2'b01:   pc_d = pc_q + 16'd1;
      2'b10:   pc_d = (!pcsel || status_q[0]) ? pc_q + k : pc_q;
      2'b11:   pc_d = regs_q[aa];
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      status_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (ir_en) ir_q <= databus;
      if (wr) regs_q[da] <= databus;
      if (wr && en_alu) status_q <= {ovf, carry, alu[15], alu == 16'd0};
    end
  end

  // Memories carry no reset; RAM writes are suppressed while reset is low
  always_ff @(posedge clock) begin
    if (bus.prog_we) rom_q[bus.prog_addr] <= bus.prog_data;
    if (reset && mw) ram_q[addr[7:0]] <= databus;
  end

  assign bus.R0             = regs_q[0];
  assign bus.R1             = regs_q[1];
  assign bus.R2             = regs_q[2];
  assign bus.R3             = regs_q[3];
  assign bus.R4             = regs_q[4];
  assign bus.R5             = regs_q[5];
  assign bus.R6             = regs_q[6];
  assign bus.R7             = regs_q[7];
  assign bus.PS             = ps;
  assign bus.databus        = databus;
  assign bus.addressbus     = addr;
  assign bus.WR             = wr;
  assign bus.ControlWord    = cw;
  assign bus.K              = k;
  assign bus.AA             = aa;
  assign bus.BA             = ba;
  assign bus.DA             = da;
  assign bus.status         = status_q;
  assign bus.FS             = fs;
  assign bus.C0             = c0;
  assign bus.PCSEL          = pcsel;
  assign bus.EN_ALU         = en_alu;
  assign bus.EN_ADDRESS_ALU = en_addr_alu;
  assign bus.IR_EN          = ir_en;
  assign bus.EN_ADDRESS_PC  = en_addr_pc;
  assign bus.EN_PC          = en_pc;
  assign bus.MW             = mw;
  assign bus.MR             = mr;
  assign bus.BSEL           = bsel;
  assign bus.ROM_EN         = rom_en;
  assign bus.EN_B           = en_b;
endmodule

`default_nettype wire

// File: tb/tb_processor.sv
// tb_processor: directed programs with hand-computed register/status/PC values.
`default_nettype none

module tb_processor;
  logic clock;
  logic reset;
  int   checks;
  int   passes;
  int   fails;
  logic [15:0] prog [256];

  localparam logic [46:0] CW_FETCH = 47'h2000_0000_20C2;
  localparam logic [46:0] CW_HALT  = 47'h4000_0000_0000;

  processor_if bus ();

  processor dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [5:0] lo);
    return {op, d, a, lo};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Holds reset low while the whole ROM image is written
  task automatic load_rom();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'(i);
      bus.prog_data = prog[i];
    end
    @(negedge clock);
    bus.prog_we = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    checks = 0;
    passes = 0;
    fails  = 0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 8'h00;
    bus.prog_data = 16'h0000;

    // Program 1: arithmetic, memory, sign-extended immediate, jump, halt
    clear_prog();
    prog[0]  = ins(4'hA, 3'd1, 3'd0, 6'd5);         // LDI R1,5
    prog[1]  = ins(4'hA, 3'd2, 3'd0, 6'd3);         // LDI R2,3
    prog[2]  = ins(4'h1, 3'd3, 3'd1, {3'd2, 3'd0}); // ADD R3,R1,R2
    prog[3]  = ins(4'h2, 3'd4, 3'd2, {3'd1, 3'd0}); // SUB R4,R2,R1
    prog[4]  = ins(4'hC, 3'd0, 3'd1, {3'd2, 3'd0}); // ST [R1],R2
    prog[5]  = ins(4'hB, 3'd5, 3'd1, 6'd0);         // LD R5,[R1]
    prog[6]  = ins(4'hA, 3'd6, 3'd0, 6'h3F);        // LDI R6,-1
    prog[7]  = ins(4'hA, 3'd7, 3'd0, 6'h10);        // LDI R7,16
    prog[8]  = ins(4'hE, 3'd0, 3'd7, 6'd0);         // JMP R7
    prog[16] = ins(4'hF, 3'd0, 3'd0, 6'd0);         // HALT
    load_rom();

    check("rst_R0", bus.R0, 16'h0000);
    check("rst_R7", bus.R7, 16'h0000);
    check("rst_pc", dut.pc_q, 16'h0000);
    check("rst_status", bus.status, 4'h0);
    release_reset();
    check("rst_cw_fetch", bus.ControlWord, CW_FETCH);
    check("rst_addrbus", bus.addressbus, 16'h0000);

    run(6);
    check("add_R1", bus.R1, 16'h0005);
    check("add_R2", bus.R2, 16'h0003);
    check("add_R3", bus.R3, 16'h0008);
    check("add_status", bus.status, 4'b0000);
    run(2);
    check("sub_R4", bus.R4, 16'hFFFE);
    check("sub_status", bus.status, 4'b0010);
    check("st_fetch_mw", bus.MW, 1'b0);
    run(1);
    check("st_exec_mw", bus.MW, 1'b1);
    check("st_exec_addr", bus.addressbus, 16'h0005);
    check("st_exec_data", bus.databus, 16'h0003);
    run(1);
    check("st_after_mw", bus.MW, 1'b0);
    run(2);
    check("ld_R5", bus.R5, 16'h0003);
    run(2);
    check("ldi_neg_R6", bus.R6, 16'hFFFF);
    check("ldi_neg_status", bus.status, 4'b0010);
    run(2);
    check("ldi_R7", bus.R7, 16'h0010);
    run(2);
    check("jmp_pc", dut.pc_q, 16'h0010);
    run(2);
    check("halt_pc", dut.pc_q, 16'h0011);
    check("halt_cw", bus.ControlWord, CW_HALT);
    run(10);
    check("halt_hold_pc", dut.pc_q, 16'h0011);
    check("halt_hold_cw", bus.ControlWord, CW_HALT);
    check("halt_hold_R3", bus.R3, 16'h0008);

    // Program 2: branch taken loop, then reset mid-instruction
    clear_prog();
    prog[0] = ins(4'hA, 3'd1, 3'd0, 6'd5);          // LDI R1,5
    prog[1] = ins(4'h2, 3'd6, 3'd1, {3'd1, 3'd0});  // SUB R6,R1,R1
    prog[2] = ins(4'hD, 3'd0, 3'd0, 6'h3E);         // BZ -2
    load_rom();
    check("rst2_pc", dut.pc_q, 16'h0000);
    release_reset();
    run(4);
    check("subz_R6", bus.R6, 16'h0000);
    check("subz_status", bus.status, 4'b0101);
    run(2);
    check("bz_taken_pc", dut.pc_q, 16'h0001);
    run(4);
    check("bz_loop_pc", dut.pc_q, 16'h0001);
    run(1);
    reset = 1'b0;
    #1;
    check("midrst_pc", dut.pc_q, 16'h0000);
    check("midrst_cw", bus.ControlWord, CW_FETCH);
    check("midrst_R1", bus.R1, 16'h0000);

    // Program 3: shift, negative ADDI, branch not taken
    clear_prog();
    prog[0] = ins(4'hA, 3'd1, 3'd0, 6'd5);          // LDI R1,5
    prog[1] = ins(4'h7, 3'd2, 3'd1, 6'd0);          // SHL R2,R1
    prog[2] = ins(4'h9, 3'd3, 3'd2, 6'h30);         // ADDI R3,R2,-16
    prog[3] = ins(4'hD, 3'd0, 3'd0, 6'h3E);         // BZ -2
    prog[4] = ins(4'hF, 3'd0, 3'd0, 6'd0);          // HALT
    load_rom();
    release_reset();
    run(4);
    check("shl_R2", bus.R2, 16'h000A);
    check("shl_status", bus.status, 4'b0000);
    run(2);
    check("addi_R3", bus.R3, 16'hFFFA);
    check("addi_status", bus.status, 4'b0010);
    run(2);
    check("bz_fall_pc", dut.pc_q, 16'h0004);
    run(2);
    check("halt3_cw", bus.ControlWord, CW_HALT);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

`default_nettype wire
